// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
//
// Round-robin arbiter that shares one single-port external memory bus among
// CLIENTS request/grant masters. One client is granted at a time. The grant is
// held for the client's whole access, including the time the memory reports
// busy. A single zero-grant turnaround cycle separates consecutive grants so
// tri-stated address/data drivers never overlap.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous reset, active low (0 = reset)
//   req          per-client request, bit i = client i
//   mem_busy     memory controller busy flag
//   grant        one-hot grant, bit i = client i (registered)
//   grant_valid  high whenever any grant bit is high (registered)
//   grant_id     index of the granted client, holds last value when idle
//   timeout_err  one-cycle pulse when the watchdog revokes a grant
//
// Optional feature: define MEM_ARB_WATCHDOG_EN to enable the GRANT-state
// watchdog. It revokes a grant if mem_busy has not risen within TIMEOUT cycles.
// Without the macro, timeout_err is constant 0 and GRANT waits indefinitely.
// ---------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int CLIENTS = 4,
  parameter int ID_W    = $clog2(CLIENTS),
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CLIENTS-1:0] req,
  input  logic               mem_busy,
  output logic [CLIENTS-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY,
    S_DONE,
    S_TURN
  } state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    last_id_reg, last_id_next;
  logic [ID_W-1:0]    grant_id_reg, grant_id_next;
  logic [CLIENTS-1:0] grant_reg, grant_next;
  logic               grant_valid_reg, grant_valid_next;
  logic               timeout_err_reg, timeout_err_next;
  logic               wd_expire;

  // -------------------------------------------------------------------------
  // Round-robin selection.
  // Candidate gi is the client (base + 1 + gi) mod CLIENTS, so candidate 0
  // has the highest priority. In TURN, the arbitration base is the client
  // that was just served. This lets the arbiter grant a pending request on
  // the edge that leaves TURN, so only one zero-grant cycle separates grants.
  // -------------------------------------------------------------------------
  logic [ID_W-1:0]    arb_base;
  logic [ID_W-1:0]    arb_sel;
  logic [ID_W-1:0]    cand_id [CLIENTS];
  logic [CLIENTS-1:0] cand_req;
  logic [CLIENTS-1:0] id_onehot;

  assign arb_base = (state_reg == S_TURN) ? grant_id_reg : last_id_reg;

  generate
    for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum          = {1'b0, arb_base} + (ID_W+1)'(gi + 1);
      assign cand_id[gi]  = (sum >= (ID_W+1)'(CLIENTS)) ? ID_W'(sum - (ID_W+1)'(CLIENTS))
                                                         : ID_W'(sum);
      assign cand_req[gi] = req[cand_id[gi]];
      // One-hot decode of the grant index that the next edge will load.
      assign id_onehot[gi] = (grant_id_next == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    arb_sel = arb_base;
    // Scan downward so the lowest-numbered candidate (nearest to base+1) wins.
    for (int k = CLIENTS - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        arb_sel = cand_id[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Watchdog on the GRANT state.
  // -------------------------------------------------------------------------
  localparam int WD_W = $clog2(TIMEOUT + 1);

`ifdef MEM_ARB_WATCHDOG_EN
  logic [WD_W-1:0] wdog_reg;
  logic [WD_W-1:0] wdog_inc;

  assign wdog_inc  = wdog_reg + 1'b1;
  // The counter has reached TIMEOUT when this GRANT cycle completes.
  assign wd_expire = (wdog_inc == WD_W'(TIMEOUT));

  // The counter stays at zero outside GRANT, so it always starts from zero
  // when GRANT is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_reg <= '0;
    end else if (state_reg == S_GRANT) begin
      wdog_reg <= wdog_inc;
    end else begin
      wdog_reg <= '0;
    end
  end
`else
  logic [WD_W-1:0] timeout_unused;
  assign timeout_unused = WD_W'(TIMEOUT);
  assign wd_expire      = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State and registered-output register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      last_id_reg     <= ID_W'(CLIENTS - 1);
      grant_id_reg    <= '0;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_id_reg     <= last_id_next;
      grant_id_reg    <= grant_id_next;
      grant_reg       <= grant_next;
      grant_valid_reg <= grant_valid_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    last_id_next  = last_id_reg;
    case (state_reg)
      S_IDLE: begin
        // mem_busy is deliberately ignored here.
        if (req != '0) begin
          state_next    = S_GRANT;
          grant_id_next = arb_sel;
        end
      end
      S_GRANT: begin
        // mem_busy takes priority over a withdrawn request: the access has started.
        if (mem_busy) begin
          state_next = S_BUSY;
        end else if (!req[grant_id_reg] || wd_expire) begin
          state_next = S_TURN;
        end
      end
      S_BUSY: begin
        if (!mem_busy) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!req[grant_id_reg]) begin
          state_next = S_TURN;
        end
      end
      S_TURN: begin
        last_id_next = grant_id_reg;
        if (req != '0) begin
          state_next    = S_GRANT;
          grant_id_next = arb_sel;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. All outputs are registered; the values are derived from
  // the state being entered.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_next       = '0;
    grant_valid_next = 1'b0;
    timeout_err_next = 1'b0;
    if (state_next == S_GRANT || state_next == S_BUSY || state_next == S_DONE) begin
      grant_next       = id_onehot;
      grant_valid_next = 1'b1;
    end
    // Flag only a true watchdog revocation, not a voluntary withdrawal.
    if (state_reg == S_GRANT && !mem_busy && req[grant_id_reg] && wd_expire) begin
      timeout_err_next = 1'b1;
    end
  end

  assign grant       = grant_reg;
  assign grant_valid = grant_valid_reg;
  assign grant_id    = grant_id_reg;
  assign timeout_err = timeout_err_reg;

endmodule
